// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } lsu_op_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Widest destination register address a tag can carry (REG_AW must not exceed it).
  localparam int TAG_WD_W = 5;

  typedef struct packed {
    logic [TAG_WD_W-1:0] wd;
    lsu_op_t             op;
    logic [1:0]          off;
    logic                discard;
  } lsu_tag_t;

  function automatic logic is_load(input lsu_op_t op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Bus size code: 0 = byte, 1 = half, 2 = word.
  function automatic logic [1:0] op_size(input lsu_op_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd2;
      default:              return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_tag_fifo.sv
// In-order tag FIFO tracking outstanding bus requests; flush marks every entry discarded.
module lsu_tag_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  lsu_tag_t      push_tag,
  input  logic          pop,
  input  logic          flush,
  output lsu_tag_t      head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_tag_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_reg;
  logic          push_eff;
  logic          pop_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign head     = mem[rd_ptr];
  assign push_eff = push && !full;
  // A response with nothing outstanding is ignored.
  assign pop_eff  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (push_eff) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_eff)  rd_ptr <= ptr_inc(rd_ptr);
      count_reg <= count_reg + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // Tag storage: a slot takes a new tag on push, otherwise flush raises its discard flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_eff && (wr_ptr == PW'(i))) mem[i] <= push_tag;
        else if (flush)                     mem[i].discard <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: alignment checks, store lane steering, pipelined bus
// requests with up to DEPTH outstanding, and in-order extended load writeback.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [REG_AW-1:0] req_wd,
  output logic              req_ready,
  output logic              mem_stall,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_wd,
  output logic [31:0]       wb_wdata,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [31:0]       exc_badvaddr
);

  localparam int CW = $clog2(DEPTH + 1);

  lsu_op_t       op;
  logic          ld, st, mem_op, misalign;
  logic [1:0]    size;
  logic          issue, accept;
  logic [31:0]   wdata;
  logic [3:0]    strb;
  lsu_tag_t      push_tag;
  lsu_tag_t      head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          wb_take;
  logic [7:0]    byte_src;
  logic [15:0]   half_src;
  logic [31:0]   ext_data;
  logic          unused_count;

  assign op = lsu_op_t'(req_op);

  // Decode the op and check natural alignment for its access size.
  always_comb begin
    ld       = is_load(op);
    st       = is_store(op);
    mem_op   = ld || st;
    size     = op_size(op);
    misalign = ((size == 2'd1) && req_addr[0]) ||
               ((size == 2'd2) && (req_addr[1:0] != 2'b00));
  end

  // No bypass: a full FIFO blocks the request even if a response pops this cycle.
  assign issue  = req_valid && mem_op && !misalign && !fifo_full && !flush;
  assign accept = rst && issue && data_addr_ok;

  // Replicate store data across lanes and derive byte enables from the offset.
  always_comb begin
    wdata = req_wdata;
    strb  = 4'b1111;
    case (size)
      2'd0: begin
        wdata = {4{req_wdata[7:0]}};
        strb  = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        wdata = {2{req_wdata[15:0]}};
        strb  = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        wdata = req_wdata;
        strb  = 4'b1111;
      end
    endcase
  end

  // Every combinational output is forced low while reset is held.
  assign data_req     = rst && issue;
  assign data_wr      = rst && req_valid && st;
  assign data_size    = rst ? size : 2'd0;
  assign data_addr    = rst ? req_addr : 32'd0;
  assign data_wdata   = (rst && st) ? wdata : 32'd0;
  assign data_wstrb   = (rst && req_valid && st) ? strb : 4'd0;
  assign req_ready    = rst && req_valid && (!mem_op || misalign || accept);
  assign mem_stall    = rst && req_valid && !req_ready;
  assign exc_valid    = rst && req_valid && mem_op && misalign;
  assign exc_code     = exc_valid ? (st ? EXC_ADES : EXC_ADEL) : 5'd0;
  assign exc_badvaddr = exc_valid ? req_addr : 32'd0;

  // Build the tag remembered for each accepted request.
  always_comb begin
    push_tag                 = '0;
    push_tag.wd[REG_AW-1:0]  = req_wd;
    push_tag.op              = op;
    push_tag.off             = req_addr[1:0];
    push_tag.discard         = 1'b0;
  end

  lsu_tag_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_tag (push_tag),
    .pop      (data_data_ok),
    .flush    (flush),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Occupancy is exposed by the FIFO for debug; issue gating only needs full.
  assign unused_count = ^fifo_count;

  // A flush arriving with a response discards that response too.
  assign wb_take = data_data_ok && !fifo_empty && is_load(head.op) && !head.discard && !flush;

  // Align the addressed byte/half to bit 0 and extend according to the load type.
  always_comb begin
    byte_src = 8'(data_rdata >> {head.off, 3'b000});
    half_src = 16'(data_rdata >> {head.off[1], 4'b0000});
    ext_data = data_rdata;
    case (head.op)
      OP_LB:   ext_data = {{24{byte_src[7]}}, byte_src};
      OP_LBU:  ext_data = {24'd0, byte_src};
      OP_LH:   ext_data = {{16{half_src[15]}}, half_src};
      OP_LHU:  ext_data = {16'd0, half_src};
      default: ext_data = data_rdata;
    endcase
  end

  // Register the writeback one cycle after the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_wd    <= '0;
      wb_wdata <= '0;
    end else begin
      wb_valid <= wb_take;
      if (wb_take) begin
        wb_wd    <= head.wd[REG_AW-1:0];
        wb_wdata <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the bus protocol.
module tb_mem_lsu;
  import lsu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_wd = 5'd0;
  logic        req_ready, mem_stall;
  logic        flush = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;

  always #5 clk = ~clk;

  mem_lsu #(.DEPTH(DEPTH), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wd(req_wd),
    .req_ready(req_ready), .mem_stall(mem_stall), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
  );

  // Reference model: outstanding bus requests in issue order.
  typedef struct {
    logic [3:0] op;
    logic [1:0] off;
    logic [4:0] wd;
    bit         discard;
  } mtag_t;

  mtag_t q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  bit    last_rdy;
  logic  seen_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic bit m_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit m_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  // Access width in bytes.
  function automatic int m_size(input logic [3:0] op);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW) return 4;
    return 1;
  endfunction

  function automatic logic [3:0] m_strobe(input int off, input int n);
    logic [3:0] s = 4'd0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_lanes(input logic [31:0] rt, input int n);
    logic [31:0] w = 32'd0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = rt[8*(b % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_extract(input logic [3:0] op, input int off, input logic [31:0] rd);
    int n = m_size(op);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
    if ((op == OP_LB || op == OP_LH) && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [4:0] wd, input bit aok,
                       input bit dok, input logic [31:0] rd, input bit fl);
    req_valid = v; req_op = op; req_addr = addr; req_wdata = rt; req_wd = wd;
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd; flush = fl;
  endtask

  // One clock: drive, check combinational outputs at negedge, advance the model,
  // then check the registered writeback just after the rising edge.
  task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic [4:0] wd, input bit aok,
                       input bit dok, input logic [31:0] rd, input bit fl);
    bit memop, mis, e_req, e_exc, e_rdy, nv;
    int n;
    mtag_t t;
    logic [4:0]  nwd;
    logic [31:0] ndata;
    drive(v, op, addr, rt, wd, aok, dok, rd, fl);
    @(negedge clk);
    n     = m_size(op);
    memop = m_load(op) || m_store(op);
    mis   = memop && ((addr & 32'(n - 1)) != 0);
    e_req = rst && v && memop && !mis && (q.size() < DEPTH) && !fl;
    e_exc = rst && v && memop && mis;
    e_rdy = rst && v && (!memop || mis || (e_req && aok));
    seen_stall = mem_stall;
    check("data_req", data_req, e_req);
    check("req_ready", req_ready, e_rdy);
    check("mem_stall", mem_stall, rst && v && !e_rdy);
    check("exc_valid", exc_valid, e_exc);
    if (e_exc) begin
      check("exc_code", exc_code, m_store(op) ? 5'd5 : 5'd4);
      check("exc_badvaddr", exc_badvaddr, addr);
    end
    if (e_req) begin
      check("data_wr", data_wr, m_store(op));
      check("data_size", data_size, (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2);
      check("data_addr", data_addr, addr);
      if (m_store(op)) begin
        check("data_wdata", data_wdata, m_lanes(rt, n));
        check("data_wstrb", data_wstrb, m_strobe(int'(addr[1:0]), n));
      end else begin
        check("data_wstrb_ld", data_wstrb, 4'd0);
      end
    end
    if (!rst) begin
      check("rst_wstrb", data_wstrb, 4'd0);
      check("rst_wr", data_wr, 1'b0);
      check("rst_addr", data_addr, 32'd0);
      check("rst_wdata", data_wdata, 32'd0);
    end
    last_rdy = e_rdy;
    nv = 1'b0; nwd = 5'd0; ndata = 32'd0;
    if (rst) begin
      if (dok && q.size() > 0) begin
        t = q.pop_front();
        if (m_load(t.op) && !t.discard && !fl) begin
          nv = 1'b1; nwd = t.wd; ndata = m_extract(t.op, int'(t.off), rd);
        end
      end
      if (fl) foreach (q[i]) q[i].discard = 1'b1;
      if (e_req && aok) begin
        q.push_back('{op, addr[1:0], wd, 1'b0});
        $display("issue op=%0d addr=%h wd=%0d rt=%h", op, addr, wd, rt);
      end
    end else begin
      q.delete();
    end
    @(posedge clk); #1;
    check("wb_valid", wb_valid, nv);
    if (nv) begin
      check("wb_wd", wb_wd, nwd);
      check("wb_wdata", wb_wdata, ndata);
      $display("wb    wd=%0d data=%h", wb_wd, wb_wdata);
    end
    if (!rst) begin
      check("rst_wb_wd", wb_wd, 5'd0);
      check("rst_wb_wdata", wb_wdata, 32'd0);
    end
  endtask

  bit          cv;
  logic [3:0]  cop;
  logic [31:0] caddr, crt;
  logic [4:0]  cwd;

  initial begin
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset: outputs held low even with an op and bus handshakes present.
    cycle(1, OP_SW, 32'h202, 32'h1234ABCD, 5'd3, 1, 1, 32'h55, 0);
    cycle(1, OP_LW, 32'h101, 32'h0, 5'd3, 1, 0, 32'h0, 0);
    rst = 1'b1;

    // LW with a three-cycle response gap.
    cycle(1, OP_LW, 32'h100, 32'h0, 5'd7, 1, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'hDEADBEEF, 0);
    check("t1_wb_wdata", wb_wdata, 32'hDEADBEEF);
    check("t1_wb_wd", wb_wd, 5'd7);

    // Byte/half extraction from 0x80112233.
    cycle(1, OP_LB, 32'h103, 32'h0, 5'd1, 1, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h80112233, 0);
    check("t2_lb", wb_wdata, 32'hFFFFFF80);
    cycle(1, OP_LBU, 32'h103, 32'h0, 5'd2, 1, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h80112233, 0);
    check("t2_lbu", wb_wdata, 32'h00000080);
    cycle(1, OP_LH, 32'h102, 32'h0, 5'd3, 1, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h80112233, 0);
    check("t2_lh", wb_wdata, 32'hFFFF8011);

    // SH lane replication and strobes, held one cycle by addr_ok low.
    drive(1, OP_SH, 32'h202, 32'h1234ABCD, 5'd0, 0, 0, 32'h0, 0);
    @(negedge clk);
    check("t3_wdata", data_wdata, 32'hABCDABCD);
    check("t3_wstrb", data_wstrb, 4'b1100);
    check("t3_size", data_size, 2'd1);
    check("t3_stall", mem_stall, 1'b1);
    @(posedge clk); #1;
    cycle(1, OP_SH, 32'h202, 32'h1234ABCD, 5'd0, 1, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h0, 0);
    check("t3_no_wb", wb_valid, 1'b0);

    // Misaligned word load.
    drive(1, OP_LW, 32'h101, 32'h0, 5'd4, 1, 0, 32'h0, 0);
    @(negedge clk);
    check("t4_exc_valid", exc_valid, 1'b1);
    check("t4_exc_code", exc_code, 5'd4);
    check("t4_badvaddr", exc_badvaddr, 32'h101);
    check("t4_data_req", data_req, 1'b0);
    check("t4_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // FIFO full: third load stalls until the first response, then issues.
    cycle(1, OP_LW, 32'h10, 32'h0, 5'd1, 1, 0, 32'h0, 0);
    cycle(1, OP_LW, 32'h14, 32'h0, 5'd2, 1, 0, 32'h0, 0);
    cycle(1, OP_LW, 32'h18, 32'h0, 5'd3, 1, 0, 32'h0, 0);
    check("t5_stall", seen_stall, 1'b1);
    cycle(1, OP_LW, 32'h18, 32'h0, 5'd3, 1, 1, 32'hA1, 0);
    check("t5_stall_pop", seen_stall, 1'b1);
    check("t5_wb1", wb_wd, 5'd1);
    cycle(1, OP_LW, 32'h18, 32'h0, 5'd3, 1, 1, 32'hB2, 0);
    check("t5_issue", seen_stall, 1'b0);
    check("t5_wb2", wb_wd, 5'd2);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'hC3, 0);
    check("t5_wb3", wb_wd, 5'd3);

    // Flush discards in-flight loads; the next load writes back normally.
    cycle(1, OP_LW, 32'h20, 32'h0, 5'd4, 1, 0, 32'h0, 0);
    cycle(1, OP_LW, 32'h24, 32'h0, 5'd5, 1, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 1);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h11, 0);
    check("t6_drop1", wb_valid, 1'b0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h22, 0);
    check("t6_drop2", wb_valid, 1'b0);
    cycle(1, OP_LW, 32'h28, 32'h0, 5'd6, 1, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h33, 0);
    check("t6_wb_wd", wb_wd, 5'd6);
    check("t6_wb_wdata", wb_wdata, 32'h33);

    // Randomized traffic; an unconsumed op is held until the unit takes it.
    last_rdy = 1'b1;
    cv = 1'b0; cop = OP_NONE; caddr = 32'd0; crt = 32'd0; cwd = 5'd0;
    for (int k = 0; k < 1500; k++) begin
      if (!cv || last_rdy) begin
        cv    = ($urandom_range(0, 9) < 8);
        cop   = 4'($urandom_range(0, 8));
        caddr = $urandom();
        if ($urandom_range(0, 1) == 1) caddr = caddr & ~32'(m_size(cop) - 1);
        crt   = $urandom();
        cwd   = 5'($urandom_range(0, 31));
      end
      cycle(cv, cop, caddr, crt, cwd,
            $urandom_range(0, 3) != 0,
            (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0),
            $urandom(), $urandom_range(0, 29) == 0);
    end

    // Reset with requests in flight, then confirm the FIFO restarts empty.
    cycle(1, OP_LW, 32'h40, 32'h0, 5'd9, 1, 0, 32'h0, 0);
    rst = 1'b0;
    cycle(1, OP_LW, 32'h44, 32'h0, 5'd9, 1, 1, 32'h77, 0);
    rst = 1'b1;
    cycle(1, OP_LH, 32'h46, 32'h0, 5'd10, 1, 0, 32'h0, 0);
    cycle(1, OP_LBU, 32'h47, 32'h0, 5'd11, 1, 0, 32'h0, 0);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'hF00D8123, 0);
    check("rst_wb_lh", wb_wdata, 32'hFFFFF00D);
    cycle(0, OP_NONE, 32'h0, 32'h0, 5'd0, 0, 1, 32'h9A000000, 0);
    check("rst_wb_lbu", wb_wdata, 32'h0000009A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised load/store unit for the MEM stage; successor to the single-outstanding data-memory access logic.
- Accepts one memory op per cycle from the EX/MEM register and drives the sram-like data bus (req/addr_ok/data_ok), with up to DEPTH requests in flight.
- Generates byte strobes, checks alignment (AdEL/AdES), extracts and extends load data.
- Returns in-order load writebacks to the MEM/WB path, and supports flush of in-flight responses.

Parameters:
- DEPTH, 2, max outstanding bus requests; power of two, >=1.
- REG_AW, 5, destination register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  op present from pipeline.
- req_op  in  4  lsu_op_t (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW).
- req_addr  in  32  effective address.
- req_wdata  in  32  store source (rt).
- req_wd  in  REG_AW  load destination register.
- req_ready  out  1  op consumed this cycle.
- mem_stall  out  1  req_valid & !req_ready.
- flush  in  1  discard all in-flight load results.
- data_req  out  1  bus request.
- data_wr  out  1  1 = store.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  bus address; equals req_addr, not word-masked.
- data_wdata  out  32  lane-replicated store data.
- data_wstrb  out  4  byte enables; 0 for loads.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response or store completion, in order.
- data_rdata  in  32  raw read word.
- wb_valid  out  1  load result valid; one-cycle pulse.
- wb_wd  out  REG_AW  destination register.
- wb_wdata  out  32  extended load data.
- exc_valid  out  1  address error this cycle.
- exc_code  out  5  4 = AdEL, 5 = AdES.
- exc_badvaddr  out  32  faulting address.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FIFO empty; count = 0.
  - wb_valid = 0, wb_wd = 0, wb_wdata = 0.
  - All combinational outputs evaluate to 0 while in reset.
- Misalignment:
  - Half op with addr[0] = 1, or word op with addr[1:0] != 0, is misaligned.
  - Same cycle: exc_valid = 1; exc_code = 4 for loads, 5 for stores; exc_badvaddr = req_addr; req_ready = 1; data_req = 0.
- NONE op: req_ready = 1, no bus activity.
- Bus request:
  - data_req = req_valid & legal & memory op & count < DEPTH & !flush.
  - Acceptance = data_req & data_addr_ok; req_ready = acceptance. Otherwise the op holds (mem_stall).
  - On acceptance, push tag {wd, op, addr[1:0], discard = 0}.
  - When count == DEPTH, data_req = 0 even if a pop occurs in the same cycle. No bypass.
- Store data:
  - SB: wdata = {4{b}}, strb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, strb = 0011 << (2*addr[1]).
  - SW: wdata = rt, strb = 1111.
- Response:
  - data_data_ok pops the FIFO head.
  - If head is a load and discard = 0, then in the next cycle: wb_valid = 1, wb_wd = tag.wd, wb_wdata = extracted data.
  - Latency: data_data_ok at cycle N gives wb at N+1.
  - Store responses pop with no wb.
- Extraction, byte selected by tag addr[1:0]:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: raw word.
- Simultaneous push and pop: both occur; count unchanged.
- data_data_ok while FIFO is empty: ignored; count stays 0.
- Flush:
  - Sets discard on every valid entry and blocks new requests that cycle.
  - In-flight responses are still popped, so bus ordering is preserved.
  - No wb is produced for discarded entries; issued stores complete on the bus.
  - A push and a flush cannot coincide, since data_req = 0 during flush.
- Pointers wrap modulo DEPTH.
- Reset mid-transaction: FIFO is cleared. The bus must be reset concurrently.

Decomposition:
- Package lsu_pkg holds:
  - lsu_op_t enum.
  - EXC_ADEL = 5'd4, EXC_ADES = 5'd5.
  - lsu_tag_t struct {wd, op, off, discard}.
- Sub-module lsu_tag_fifo: DEPTH-entry FIFO with push, pop, a flush-all-discard input, count, full and empty.
- Alignment check, strobe generation and extraction stay inline.

Test Plan:
- LW 0x100, bus returns 0xDEADBEEF after 3 cycles -> one data_req; wb_valid one cycle after data_ok with wb_wdata = 0xDEADBEEF and wb_wd = req_wd.
- LB 0x103 on rdata 0x80112233 -> wb_wdata = 0xFFFFFF80; LBU at the same address -> 0x00000080; LH 0x102 -> 0xFFFF8011.
- SH 0x202 with rt = 0x1234ABCD -> data_wdata = 0xABCDABCD, data_wstrb = 1100, data_size = 1, no wb.
- LW 0x101 -> exc_valid = 1, exc_code = 4, exc_badvaddr = 0x101, data_req = 0, req_ready = 1.
- DEPTH = 2, three back-to-back loads with data_ok withheld -> third load stalls (mem_stall = 1) until the first data_ok, is issued the following cycle, and wb order matches issue order.
- Two loads in flight, flush pulsed, then two data_ok -> no wb_valid; the next load after the flush writes back normally.
